// File: rtl/vec_op_sequencer_pkg.sv
// Shared types and encodings for the packed-lane vector sequencer.
package vec_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;

    localparam logic [6:0] OPC_VEC = 7'b0001011;
    localparam logic [2:0] F3_ADDV = 3'b000;
    localparam logic [2:0] F3_AVGV = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SRL = 3'b011;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_ADDV) || (f3 == F3_AVGV);
    endfunction

endpackage

// File: rtl/vec_op_sequencer_if.sv
// Core-side bundle of the sequencer: decode/regfile inputs, ALU borrow path, writeback.
interface vec_op_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [4:0]      rd;
    logic            alu_req;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] alu_y;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic            illegal;

    modport master (
        output start, funct3, src_a, src_b, rd, alu_y,
        input  alu_req, alu_a, alu_b, alu_op, busy, done, result, wb_en, wb_rd, illegal
    );

    modport slave (
        input  start, funct3, src_a, src_b, rd, alu_y,
        output alu_req, alu_a, alu_b, alu_op, busy, done, result, wb_en, wb_rd, illegal
    );
endinterface

// File: rtl/vec_op_sequencer_lane_mux.sv
// Selects lane k of a packed word and zero-extends it to the full datapath width.
module vec_lane_mux #(
    parameter int XLEN   = 32,
    parameter int LANE_W = 8,
    parameter int KW     = 2
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [KW-1:0]   k_i,
    output logic [XLEN-1:0] lane_o
);
    assign lane_o = XLEN'(word_i[k_i*LANE_W +: LANE_W]);
endmodule

// File: rtl/vec_op_sequencer.sv
// ADD_V / AVG_V sequencer that borrows the core ALU one lane per pass.
// Define VEC_SAT_EN to make ADD_V saturate each lane instead of wrapping.
module vec_op_sequencer
    import vec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LANE_W = 8
) (
    input  logic clk,
    input  logic reset,
    vec_op_sequencer_if.slave bus
);
    localparam int LANES = XLEN / LANE_W;
    localparam int KW    = (LANES > 1) ? $clog2(LANES) : 1;

    state_e            state_q;
    logic [KW-1:0]     k_q;
    logic [XLEN-1:0]   a_q, b_q, result_q;
    logic [4:0]        rd_q, wb_rd_q;
    logic              avg_q, done_q, wb_en_q, illegal_q;
    logic [LANE_W:0]   sum_q;

    logic [XLEN-1:0]   lane_a, lane_b;
    logic [LANE_W:0]   sum_d;
    logic [LANE_W-1:0] lane_d;
    logic              lane_wr_d, last_d;
    logic              unused_alu_hi;

    vec_lane_mux #(.XLEN(XLEN), .LANE_W(LANE_W), .KW(KW)) u_mux_a (
        .word_i(a_q), .k_i(k_q), .lane_o(lane_a));
    vec_lane_mux #(.XLEN(XLEN), .LANE_W(LANE_W), .KW(KW)) u_mux_b (
        .word_i(b_q), .k_i(k_q), .lane_o(lane_b));

    assign sum_d         = bus.alu_y[LANE_W:0];
    assign last_d        = (k_q == KW'(LANES - 1));
    assign unused_alu_hi = ^bus.alu_y[XLEN-1:LANE_W+1];

    // Lane writeback value: add result in EXEC (ADD_V only), shifted sum in SHIFT.
    always_comb begin
        lane_wr_d = 1'b0;
        lane_d    = '0;
        if (state_q == EXEC && !avg_q) begin
            lane_wr_d = 1'b1;
`ifdef VEC_SAT_EN
            lane_d    = sum_d[LANE_W] ? '1 : sum_d[LANE_W-1:0];
`else
            lane_d    = sum_d[LANE_W-1:0];
`endif
        end else if (state_q == SHIFT) begin
            lane_wr_d = 1'b1;
            lane_d    = bus.alu_y[LANE_W-1:0];
        end
    end

    always_comb begin
        bus.alu_req = 1'b0;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_op  = '0;
        case (state_q)
            EXEC: begin
                bus.alu_req = 1'b1;
                bus.alu_a   = lane_a;
                bus.alu_b   = lane_b;
                bus.alu_op  = ALU_ADD;
            end
            SHIFT: begin
                bus.alu_req = 1'b1;
                bus.alu_a   = XLEN'(sum_q);
                bus.alu_b   = XLEN'(1);
                bus.alu_op  = ALU_SRL;
            end
            default: ;
        endcase
    end

    // busy rises combinationally with an accepted start so fetch stalls that same cycle.
    assign bus.busy    = (state_q == IDLE && bus.start && f3_legal(bus.funct3))
                       || state_q == EXEC || state_q == SHIFT;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_rd   = wb_rd_q;
    assign bus.illegal = illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            avg_q     <= 1'b0;
            sum_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            illegal_q <= 1'b0;
            if (lane_wr_d) result_q[k_q*LANE_W +: LANE_W] <= lane_d;
            case (state_q)
                IDLE: if (bus.start) begin
                    if (f3_legal(bus.funct3)) begin
                        a_q      <= bus.src_a;
                        b_q      <= bus.src_b;
                        rd_q     <= bus.rd;
                        avg_q    <= (bus.funct3 == F3_AVGV);
                        result_q <= '0;
                        k_q      <= '0;
                        state_q  <= EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end
                EXEC, SHIFT: begin
                    if (state_q == EXEC && avg_q) begin
                        sum_q   <= sum_d;
                        state_q <= SHIFT;
                    end else if (last_d) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        wb_en_q <= (rd_q != 5'd0);
                        wb_rd_q <= rd_q;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= EXEC;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_op_sequencer.sv
// Self-checking bench: directed plan plus random ops against a lane-arithmetic model.
module tb_vec_op_sequencer;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic reset;
    int   npass = 0;
    int   ntot  = 0;

    vec_op_sequencer_if #(.XLEN(32)) bus ();

    vec_op_sequencer #(.XLEN(32), .LANE_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Core ALU stand-in: add and logical shift right.
    assign bus.alu_y = (bus.alu_op == 3'b000) ? bus.alu_a + bus.alu_b :
                       (bus.alu_op == 3'b011) ? bus.alu_a >> bus.alu_b[4:0] : 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int lane(input logic [31:0] w, input int i);
        return int'((w >> (8 * i)) & 32'hFF);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = 0;
        for (int i = 0; i < LANES; i++) begin
            int s, v;
            s = lane(a, i) + lane(b, i);
            if (f3 == 3'b001) v = s / 2;
`ifdef VEC_SAT_EN
            else v = (s > 255) ? 255 : s;
`else
            else v = s % 256;
`endif
            r = r | (32'(v) << (8 * i));
        end
        return r;
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic avg = (f3 == 3'b001);
        int   lat = avg ? 2 * LANES + 1 : LANES + 1;
        logic [31:0] exp = model(f3, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.src_a = a; bus.src_b = b; bus.rd = rd;
        #1;
        chk("busy_at_start", 32'(bus.busy), 32'd1);
        chk("req_at_start", 32'(bus.alu_req), 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            // Noise on the inputs while running must be ignored.
            bus.start  = (c == lat) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.funct3 = 3'($urandom_range(0, 1));
            bus.src_a  = $urandom; bus.src_b = $urandom; bus.rd = 5'($urandom);
            #1;
            if (c < lat) begin
                logic sh = avg && (c % 2 == 0);
                int   ln = avg ? (c - 1) / 2 : c - 1;
                chk("busy_run", 32'(bus.busy), 32'd1);
                chk("done_run", 32'(bus.done), 32'd0);
                chk("req_run", 32'(bus.alu_req), 32'd1);
                chk("alu_op", 32'(bus.alu_op), sh ? 32'd3 : 32'd0);
                chk("alu_a", bus.alu_a, sh ? 32'(lane(a, ln) + lane(b, ln)) : 32'(lane(a, ln)));
                chk("alu_b", bus.alu_b, sh ? 32'd1 : 32'(lane(b, ln)));
            end else begin
                chk("done", 32'(bus.done), 32'd1);
                chk("busy_done", 32'(bus.busy), 32'd0);
                chk("req_done", 32'(bus.alu_req), 32'd0);
                chk("alu_a_idle", bus.alu_a, 32'd0);
                chk("result", bus.result, exp);
                chk("wb_en", 32'(bus.wb_en), 32'(rd != 5'd0));
                chk("wb_rd", 32'(bus.wb_rd), 32'(rd));
            end
        end
    endtask

    task automatic run_illegal(input logic [2:0] f3);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.src_a = $urandom; bus.src_b = $urandom; bus.rd = 5'd7;
        #1;
        chk("ill_busy0", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("illegal_pulse", 32'(bus.illegal), 32'd1);
        chk("ill_busy1", 32'(bus.busy), 32'd0);
        chk("ill_req", 32'(bus.alu_req), 32'd0);
        chk("ill_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        #1;
        chk("illegal_clear", 32'(bus.illegal), 32'd0);
        chk("ill_wb_en", 32'(bus.wb_en), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.funct3 = '0; bus.src_a = '0; bus.src_b = '0; bus.rd = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req", 32'(bus.alu_req), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        reset = 1'b0;

        run_op(3'b000, 32'h01020304, 32'h10203040, 5'd5);
        run_op(3'b000, 32'hFF800001, 32'h018000FF, 5'd3);
        run_op(3'b001, 32'hFF000A03, 32'hFF001405, 5'd9);
        run_illegal(3'b010);
        run_op(3'b000, 32'h01020304, 32'h10203040, 5'd0);

        // Reset three cycles into an AVG_V.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b001; bus.src_a = 32'hFF000A03; bus.src_b = 32'hFF001405; bus.rd = 5'd4;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_req", 32'(bus.alu_req), 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("midrst_no_done", 32'({bus.done, bus.wb_en}), 32'd0);
        end
        run_op(3'b000, 32'h01020304, 32'h10203040, 5'd5);

        for (int i = 0; i < 24; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 8) run_op(3'(r % 2), $urandom, $urandom, 5'($urandom));
            else       run_illegal(3'($urandom_range(2, 7)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
